// File: rtl/rom_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_if_pkg
// Purpose  : Shared constants and the reader state type for the fixed-latency
//            ROM interface and its burst reader.
// Contents : ROM_ADDR_W, ROM_DATA_W, ROM_LATENCY, ROM_INIT_CYCLES, ROM_OFFSET,
//            rom_rd_state_t.
// Revision : 1.0 - initial release
// ============================================================================
package rom_if_pkg;

  localparam int ROM_ADDR_W      = 8;
  localparam int ROM_DATA_W      = 8;
  localparam int ROM_LATENCY     = 3;
  localparam int ROM_INIT_CYCLES = 100;
  // The ROM image holds (address + ROM_OFFSET) in every location.
  localparam int ROM_OFFSET      = 1;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FIN     = 3'd5
  } rom_rd_state_t;

endpackage : rom_if_pkg
`default_nettype wire

// File: rtl/rom_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader_if
// Purpose  : Bundles the client burst-request port and the ROM bus of the
//            burst reader.
// Modports : master - the reader (drives RD/address and the result port)
//            slave  - the environment (client request + ROM data)
// Signals  : start, start_addr, length, busy, RD, address, rom_data,
//            data_out, data_valid, done, err, err_count
// Revision : 1.0 - initial release
// ============================================================================
interface rom_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              RD;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              done;
  logic              err;
  logic [7:0]        err_count;

  modport master (
    input  start, start_addr, length, rom_data,
    output busy, RD, address, data_out, data_valid, done, err, err_count
  );

  modport slave (
    output start, start_addr, length, rom_data,
    input  busy, RD, address, data_out, data_valid, done, err, err_count
  );

endinterface : rom_reader_if
`default_nettype wire

// File: rtl/rom_reader_timer.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader_timer
// Purpose  : Loadable down-counter with a zero flag. Counts down while en is
//            high and parks at zero; load has priority over counting.
// Ports    : clk, rst_n (sync, active-low), load, load_val[W], en, zero
// Revision : 1.0 - initial release
// ============================================================================
module rom_reader_timer #(
  parameter int W         = 8,
  parameter int RESET_VAL = 0
) (
  input  wire          clk,
  input  wire          rst_n,
  input  wire          load,
  input  wire  [W-1:0] load_val,
  input  wire          en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule : rom_reader_timer
`default_nettype wire

// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader
// Purpose  : Burst read initiator for the fixed-latency ROM. Waits out the
//            ROM power-up period, then issues one RD strobe per word, captures
//            each reply and presents it on a registered valid/data port.
// Ports    : CLK, RST_n (sync, active-low), bus (rom_reader_if.master)
// Options  : ROM_READER_CHECK_EN - when defined, each captured word is
//            compared with (address + ROM_OFFSET); mismatches set the sticky
//            err flag and bump the saturating err_count. When undefined, err
//            and err_count are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module rom_reader
  import rom_if_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int LATENCY     = ROM_LATENCY,
  parameter int INIT_CYCLES = ROM_INIT_CYCLES
) (
  input wire             CLK,
  input wire             RST_n,
  rom_reader_if.master   bus
);

  localparam int TMR_MAX = (INIT_CYCLES > LATENCY) ? INIT_CYCLES : LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  rom_rd_state_t       state;
  logic                rd;
  logic [ADDR_W-1:0]   address;
  logic [ADDR_W:0]     remaining;
  logic [DATA_W-1:0]   data_out;
  logic                data_valid;
  logic                done;
  logic                busy;
  logic                tmr_zero;
  logic                tmr_load;
  logic                tmr_en;

  // One timer serves both INIT and WAIT. Reset preloads INIT_CYCLES-1 so INIT
  // spans INIT_CYCLES edges; ISSUE preloads LATENCY-1 so WAIT spans LATENCY
  // edges and the capture lands LATENCY+1 edges after the ROM samples RD.
  assign tmr_load = (state == ST_ISSUE);
  assign tmr_en   = (state == ST_INIT) || (state == ST_WAIT);

  rom_reader_timer #(
    .W         (TMR_W),
    .RESET_VAL (INIT_CYCLES - 1)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RST_n),
    .load     (tmr_load),
    .load_val (TMR_W'(LATENCY - 1)),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state      <= ST_INIT;
      rd         <= 1'b0;
      address    <= '0;
      remaining  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b1;
    end else begin
      rd         <= 1'b0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_INIT: begin
          if (tmr_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.start) begin
            busy <= 1'b1;
            if (bus.length == '0) begin
              state <= ST_FIN;
            end else begin
              state     <= ST_ISSUE;
              rd        <= 1'b1;
              address   <= bus.start_addr;
              remaining <= bus.length;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          data_out   <= bus.rom_data;
          data_valid <= 1'b1;
          address    <= address + ADDR_W'(1);
          remaining  <= remaining - CNT_ONE;
          // The next strobe is registered here, so back-to-back words are
          // spaced LATENCY+2 clocks apart.
          if (remaining == CNT_ONE) begin
            state <= ST_FIN;
          end else begin
            state <= ST_ISSUE;
            rd    <= 1'b1;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.RD         = rd;
  assign bus.address    = address;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.done       = done;
  assign bus.busy       = busy;

`ifdef ROM_READER_CHECK_EN
  logic              err;
  logic [7:0]        err_count;
  logic [DATA_W-1:0] expect_data;

  assign expect_data = DATA_W'(address) + DATA_W'(ROM_OFFSET);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if ((state == ST_CAPTURE) && (bus.rom_data != expect_data)) begin
      err <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign bus.err       = err;
  assign bus.err_count = err_count;
`else
  assign bus.err       = 1'b0;
  assign bus.err_count = 8'd0;
`endif

endmodule : rom_reader
`default_nettype wire

// File: tb/tb_rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_reader
// Purpose  : Directed self-checking bench for rom_reader with a behavioural
//            fixed-latency ROM whose contents are (address + 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_reader;
  import rom_if_pkg::*;

  localparam int AW   = ROM_ADDR_W;
  localparam int DW   = ROM_DATA_W;
  localparam int LAT  = ROM_LATENCY;
  localparam int INIT = ROM_INIT_CYCLES;
`ifdef ROM_READER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_n;

  rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_reader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .LATENCY     (LAT),
    .INIT_CYCLES (INIT)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [AW-1:0] rd_addr[$];
  int            rd_edge[$];
  logic [DW-1:0] cap_data[$];
  int            cap_edge[$];
  int            done_cnt  = 0;
  int            done_edge = 0;
  bit            force_zero = 1'b0;

  // ROM model: RD sampled at edge E, data driven just after edge E+LAT.
  logic          pipe_v[1:LAT];
  logic [AW-1:0] pipe_a[1:LAT];

  initial begin
    for (int k = 1; k <= LAT; k++) begin
      pipe_v[k] = 1'b0;
      pipe_a[k] = '0;
    end
  end

  always @(posedge CLK) begin
    if (pipe_v[LAT] === 1'b1)
      bus.rom_data <= force_zero ? '0 : (DW'(pipe_a[LAT]) + DW'(ROM_OFFSET));
    for (int k = LAT; k > 1; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_a[k] = pipe_a[k-1];
    end
    pipe_v[1] = bus.RD;
    pipe_a[1] = bus.address;
  end

  // Event log, sampled 1 time unit after each rising edge.
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (bus.RD === 1'b1) begin
      rd_addr.push_back(bus.address);
      rd_edge.push_back(cyc);
    end
    if (bus.data_valid === 1'b1) begin
      cap_data.push_back(bus.data_out);
      cap_edge.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_edge = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    rd_edge.delete();
    cap_data.delete();
    cap_edge.delete();
    done_cnt = 0;
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [AW:0] n, output int s_edge);
    clear_logs();
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.length     = n;
    s_edge         = cyc + 1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; (i < bound) && (done_cnt == 0); i++) tick();
    check("done_seen", done_cnt, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},       bus.busy, 1);
    check({tag, "_rd"},         bus.RD, 0);
    check({tag, "_address"},    bus.address, 0);
    check({tag, "_data_out"},   bus.data_out, 0);
    check({tag, "_data_valid"}, bus.data_valid, 0);
    check({tag, "_done"},       bus.done, 0);
    check({tag, "_err"},        bus.err, 0);
    check({tag, "_err_count"},  bus.err_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.rom_data   = 'x;
    RST_n          = 1'b0;
    tick();
    tick();
    RST_n = 1'b1;
    check_reset_values("rst");

    // INIT: busy stays high, no RD, a start pulse is ignored.
    for (int i = 1; i <= INIT - 1; i++) begin
      if (i == 8) begin
        bus.start = 1'b1; bus.start_addr = 8'h10; bus.length = 9'd1;
      end
      if (i == 9) bus.start = 1'b0;
      tick();
      check("init_busy", bus.busy, 1);
      check("init_rd", bus.RD, 0);
    end
    tick();
    check("idle_busy", bus.busy, 0);
    check("init_no_rd", rd_addr.size(), 0);
    check("init_no_valid", cap_data.size(), 0);
    check("init_no_done", done_cnt, 0);

    // Four words from 0x10.
    start_burst(8'h10, 9'd4, s);
    wait_done(40);
    check("b4_rd_count", rd_addr.size(), 4);
    check("b4_rd_addr0", rd_addr[0], 8'h10);
    check("b4_rd_edge0", rd_edge[0] - s, 0);
    check("b4_cap_count", cap_data.size(), 4);
    check("b4_data0", cap_data[0], 8'h11);
    check("b4_data1", cap_data[1], 8'h12);
    check("b4_data2", cap_data[2], 8'h13);
    check("b4_data3", cap_data[3], 8'h14);
    check("b4_first_cap", cap_edge[0] - s, 5);
    check("b4_spacing", cap_edge[3] - cap_edge[2], 5);
    check("b4_done_lat", done_edge - s, 21);
    check("b4_done_once", done_cnt, 1);
    check("b4_err", bus.err, 0);
    check("b4_idle", bus.busy, 0);

    // Address wrap 0xFE -> 0x00.
    start_burst(8'hFE, 9'd3, s);
    wait_done(40);
    check("wrap_rd0", rd_addr[0], 8'hFE);
    check("wrap_rd1", rd_addr[1], 8'hFF);
    check("wrap_rd2", rd_addr[2], 8'h00);
    check("wrap_data0", cap_data[0], 8'hFF);
    check("wrap_data1", cap_data[1], 8'h00);
    check("wrap_data2", cap_data[2], 8'h01);
    check("wrap_done_lat", done_edge - s, 16);
    check("wrap_err", bus.err, 0);

    // Zero-length burst.
    start_burst(8'h33, 9'd0, s);
    wait_done(10);
    check("len0_done_lat", done_edge - s, 1);
    check("len0_no_rd", rd_addr.size(), 0);
    check("len0_no_valid", cap_data.size(), 0);

    // Full 256-word burst.
    start_burst(8'h00, 9'd256, s);
    wait_done(256 * 5 + 20);
    check("b256_rd_count", rd_addr.size(), 256);
    check("b256_cap_count", cap_data.size(), 256);
    check("b256_data127", cap_data[127], 8'h80);
    check("b256_last", cap_data[255], 8'h00);
    check("b256_data_out", bus.data_out, 8'h00);
    check("b256_done_lat", done_edge - s, 1281);
    check("b256_address", bus.address, 8'h00);

    // Reset during WAIT of word 2.
    start_burst(8'h20, 9'd4, s);
    while (cyc < s + 7) tick();
    check("mid_rd_count", rd_addr.size(), 2);
    RST_n = 1'b0;
    tick();
    RST_n = 1'b1;
    check_reset_values("mid");
    for (int i = 1; i <= INIT - 1; i++) begin
      tick();
      check("reinit_busy", bus.busy, 1);
    end
    tick();
    check("reinit_idle", bus.busy, 0);
    check("mid_no_done", done_cnt, 0);
    check("mid_one_cap", cap_data.size(), 1);
    check("mid_rd_total", rd_addr.size(), 2);

    start_burst(8'h40, 9'd2, s);
    wait_done(30);
    check("post_data0", cap_data[0], 8'h41);
    check("post_data1", cap_data[1], 8'h42);
    check("post_done_lat", done_edge - s, 11);

    // ROM returns 0x00 for 300 reads.
    force_zero = 1'b1;
    start_burst(8'h00, 9'd256, s);
    for (int i = 0; (i < 20) && (cap_data.size() == 0); i++) tick();
    check("fz_first_data", cap_data[0], 8'h00);
    check("fz_err_first", bus.err, CHK ? 1 : 0);
    check("fz_cnt_first", bus.err_count, CHK ? 1 : 0);
    wait_done(256 * 5 + 20);
    start_burst(8'h00, 9'd44, s);
    wait_done(44 * 5 + 20);
    check("fz_cap_count", cap_data.size(), 44);
    check("fz_err_final", bus.err, CHK ? 1 : 0);
    check("fz_cnt_sat", bus.err_count, CHK ? 8'hFF : 8'h00);
    force_zero = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rom_reader
`default_nettype wire

// File: doc/rom_reader.md
# rom_reader

Synchronous read initiator for the team's fixed-latency ROM interface (one-cycle `RD` strobe, 8-bit `address`, `data` valid a fixed number of clocks later). Accepts a burst request (start address, word count) from a client, waits out the ROM's power-up period, then issues one ROM read per word. It captures each returned word and presents it on a registered valid/data port. Sits between test or control logic and the ROM, replacing hand-written timing tasks in benches and in synthesizable datapaths.

## Interface
- `ADDR_W`, 8, ROM address width
- `DATA_W`, 8, ROM data width
- `LATENCY`, 3, ROM clocks from `RD` sample edge to data set
- `INIT_CYCLES`, 100, clocks after reset before the first `RD` is allowed
- `CLK`  in  1  clock, all logic on rising edge
- `RST_n`  in  1  synchronous active-low reset
- `start`  in  1  burst request, sampled in IDLE only
- `start_addr`  in  ADDR_W  first ROM address of burst
- `length`  in  ADDR_W+1  word count, 0..256
- `busy`  out  1  high in every state except IDLE
- `RD`  out  1  ROM read strobe, one-cycle pulse per word
- `address`  out  ADDR_W  ROM address, stable from `RD` high until capture
- `rom_data`  in  DATA_W  ROM data output; X/Z during ROM init
- `data_out`  out  DATA_W  captured word
- `data_valid`  out  1  one-cycle pulse per captured word
- `done`  out  1  one-cycle pulse at end of burst
- `err`  out  1  sticky data-check mismatch flag
- `err_count`  out  8  saturating mismatch count

## Operation
- States: INIT → IDLE → ISSUE → WAIT → CAPTURE → (ISSUE | FIN) → IDLE.
- INIT: count `INIT_CYCLES` clocks; `rom_data` is never sampled in INIT; `start` is ignored.
- IDLE: on `start`=1 with `length`≠0, latch `start_addr` and `length`, go to ISSUE. With `length`=0, go to FIN and issue no `RD`.
- ISSUE: drive `RD`=1 with `address`=current address for exactly one cycle, then go to WAIT.
- WAIT: hold `address` for `LATENCY` cycles, then go to CAPTURE.
- CAPTURE: register `rom_data` into `data_out` and pulse `data_valid`. Increment the address modulo 2^ADDR_W (0xFF wraps to 0x00) and decrement the remaining count. If the count is now zero, go to FIN; otherwise go to ISSUE.
- FIN: pulse `done`, then go to IDLE.
- `start` while `busy`: ignored, no queuing.
- Reset values: `RD`=0, `address`=0, `data_out`=0, `data_valid`=0, `done`=0, `busy`=1, `err`=0, `err_count`=0, state INIT.
- Reset mid-burst: the burst is abandoned with no `done` pulse, and INIT is re-run in full. Any ROM reply still in flight falls inside INIT and is discarded.

## Timing
- Edge numbering: the ROM samples `RD`=1 at edge E. The ROM sets `data` just after edge E+LATENCY. The reader captures at edge E+LATENCY+1. `data_valid` and `data_out` are high/valid in the cycle following that edge.
- The next `RD` is registered at the capture edge and sampled by the ROM at E+LATENCY+2. The ROM is idle again by then, so no strobe is lost.
- Per-word period: LATENCY+2 = 5 clocks.
- Burst of N words: from the `start` sample edge to the `done` pulse takes N·(LATENCY+2)+1 clocks.
- First legal `start` sample edge after reset release: edge INIT_CYCLES+1.

## Configuration
- `ROM_READER_CHECK_EN` defined: at each capture, compare `rom_data` with (address+1) mod 2^DATA_W. On mismatch, set `err` (cleared only by reset) and increment `err_count`, saturating at 255.
- `ROM_READER_CHECK_EN` not defined: no comparator is built. `err` and `err_count` remain as ports, tied to 0.

## Structure
- Package `rom_if_pkg` holds:
  - `ROM_ADDR_W`=8, `ROM_DATA_W`=8, `ROM_LATENCY`=3, `ROM_INIT_CYCLES`=100, `ROM_OFFSET`=1.
  - The reader state enum `rom_rd_state_t`.
- Sub-module `rom_reader_timer`: loadable down-counter with a zero flag, shared by INIT and WAIT. The top module holds the FSM, address/count registers, capture register and optional checker.

## Test plan
- Reset, then `start` at cycle 10 with `start_addr`=0x10, `length`=1 → no `RD` before INIT ends; `start` ignored; `busy`=1 throughout INIT.
- After INIT, `start_addr`=0x10, `length`=4 against the ROM model → `data_out` 0x11, 0x12, 0x13, 0x14 at 5-clock spacing; `done` 21 clocks after start; `err`=0.
- `start_addr`=0xFE, `length`=3 → addresses 0xFE, 0xFF, 0x00; data 0xFF, 0x00, 0x01; `err`=0.
- `length`=0 → `done` pulses with no `RD` and no `data_valid`. Then `length`=256 from 0x00 → 256 `data_valid` pulses, final `data_out`=0x00.
- Assert `RST_n`=0 for 1 cycle during WAIT of word 2 → no `done`, outputs at reset values, INIT re-run. A new burst of 2 words from 0x40 returns 0x41, 0x42.
- `ROM_READER_CHECK_EN` defined, ROM forced to return 0x00 for 300 reads → `err`=1 after the first read; `err_count` saturates at 255.
